exe_stage: RTL

Execute stage sitting directly downstream of the ID/EXE pipeline register. It consumes the decoded control word and operands, performs single-cycle ALU operations and iterative multi-cycle multiply/MAC operations for filter kernels, and drives the EXE/MEM result register. While a multi-cycle operation is in flight it stalls the upstream register.

---
 rtl/exe_stage.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus a 16-step radix-4 iterative multiplier/MAC
// that stalls upstream while busy. Define EXE_MAC_EN to build the accumulator and MAC ops.
module exe_stage #(
    parameter int MUL_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    input  logic [16:0] i_ctrl,
    input  logic [31:0] i_DatA,
    input  logic [31:0] i_DatB,
    input  logic [31:0] i_imm,
    input  logic [3:0]  i_Robj,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_result,
    output logic [31:0] o_store_data,
    output logic [3:0]  o_Robj,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic [8:0]  o_ctrl_wb
);

    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_AND    = 4'd2;
    localparam logic [3:0] OP_OR     = 4'd3;
    localparam logic [3:0] OP_XOR    = 4'd4;
    localparam logic [3:0] OP_SLL    = 4'd5;
    localparam logic [3:0] OP_SRL    = 4'd6;
    localparam logic [3:0] OP_SRA    = 4'd7;
    localparam logic [3:0] OP_SLT    = 4'd8;
    localparam logic [3:0] OP_MUL    = 4'd9;
`ifdef EXE_MAC_EN
    localparam logic [3:0] OP_MAC    = 4'd10;
    localparam logic [3:0] OP_CLRACC = 4'd11;
    localparam logic [3:0] OP_RDACC  = 4'd12;
`endif

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [31:0]     mcand_reg, mcand_next;
    logic [31:0]     mplier_reg, mplier_next;
    logic [31:0]     prod_reg, prod_next;

    // Writeback fields of the in-flight multiply, released when it completes
    logic [3:0]      pend_robj_reg, pend_robj_next;
    logic            pend_rw_reg, pend_rw_next;
    logic            pend_mr_reg, pend_mr_next;
    logic            pend_mw_reg, pend_mw_next;
    logic [8:0]      pend_wb_reg, pend_wb_next;
    logic [31:0]     pend_store_reg, pend_store_next;

    logic            stall_reg, stall_next;
    logic            valid_reg, valid_next;
    logic [31:0]     result_reg, result_next;
    logic [31:0]     store_reg, store_next;
    logic [3:0]      robj_reg, robj_next;
    logic            rw_reg, rw_next;
    logic            mr_reg, mr_next;
    logic            mw_reg, mw_next;
    logic [8:0]      wb_reg, wb_next;

`ifdef EXE_MAC_EN
    logic [31:0]     acc_reg, acc_next;
    logic            is_mac_reg, is_mac_next;
    logic [32:0]     mac_sum;
    logic [31:0]     mac_sat;
`endif

    logic [3:0]      op;
    logic [31:0]     b_op;
    logic [31:0]     alu_res;
    logic            mul_start;
    logic [31:0]     step_add;
    logic [31:0]     prod_step;

    assign op   = i_ctrl[3:0];
    assign b_op = i_ctrl[4] ? i_imm : i_DatB;

    always_comb begin
        alu_res = i_DatA;
        case (op)
            OP_ADD: alu_res = i_DatA + b_op;
            OP_SUB: alu_res = i_DatA - b_op;
            OP_AND: alu_res = i_DatA & b_op;
            OP_OR:  alu_res = i_DatA | b_op;
            OP_XOR: alu_res = i_DatA ^ b_op;
            OP_SLL: alu_res = i_DatA << b_op[4:0];
            OP_SRL: alu_res = i_DatA >> b_op[4:0];
            OP_SRA: alu_res = $unsigned($signed(i_DatA) >>> b_op[4:0]);
            OP_SLT: alu_res = {31'd0, $signed(i_DatA) < $signed(b_op)};
`ifdef EXE_MAC_EN
            OP_CLRACC: alu_res = 32'd0;
            OP_RDACC:  alu_res = acc_reg;
`endif
            default: alu_res = i_DatA;
        endcase
    end

`ifdef EXE_MAC_EN
    assign mul_start = (op == OP_MUL) || (op == OP_MAC);
`else
    assign mul_start = (op == OP_MUL);
`endif

    // Radix-4 step: add 0/1/2/3 times the shifted multiplicand
    always_comb begin
        case (mplier_reg[1:0])
            2'd0:    step_add = 32'd0;
            2'd1:    step_add = mcand_reg;
            2'd2:    step_add = mcand_reg << 1;
            default: step_add = mcand_reg + (mcand_reg << 1);
        endcase
    end
    assign prod_step = prod_reg + step_add;

`ifdef EXE_MAC_EN
    // Product of sign-extended 16-bit operands is exact in 32 bits
    assign mac_sum = {acc_reg[31], acc_reg} + {prod_step[31], prod_step};
    assign mac_sat = (mac_sum[32] != mac_sum[31])
                   ? (mac_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                   : mac_sum[31:0];
`endif

    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        mcand_next      = mcand_reg;
        mplier_next     = mplier_reg;
        prod_next       = prod_reg;
        pend_robj_next  = pend_robj_reg;
        pend_rw_next    = pend_rw_reg;
        pend_mr_next    = pend_mr_reg;
        pend_mw_next    = pend_mw_reg;
        pend_wb_next    = pend_wb_reg;
        pend_store_next = pend_store_reg;
        stall_next      = stall_reg;
        valid_next      = valid_reg;
        result_next     = result_reg;
        store_next      = store_reg;
        robj_next       = robj_reg;
        rw_next         = rw_reg;
        mr_next         = mr_reg;
        mw_next         = mw_reg;
        wb_next         = wb_reg;
`ifdef EXE_MAC_EN
        acc_next        = acc_reg;
        is_mac_next     = is_mac_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (i_valid && mul_start) begin
                    state_next      = S_BUSY;
                    count_next      = CW'(MUL_CYCLES - 1);
                    mcand_next      = i_DatA;
                    mplier_next     = b_op;
                    prod_next       = 32'd0;
                    pend_robj_next  = i_Robj;
                    pend_rw_next    = i_ctrl[5];
                    pend_mr_next    = i_ctrl[6];
                    pend_mw_next    = i_ctrl[7];
                    pend_wb_next    = i_ctrl[16:8];
                    pend_store_next = i_DatB;
                    stall_next      = 1'b1;
                    valid_next      = 1'b0;
                    rw_next         = 1'b0;
                    mr_next         = 1'b0;
                    mw_next         = 1'b0;
`ifdef EXE_MAC_EN
                    is_mac_next     = (op == OP_MAC);
                    if (op == OP_MAC) begin
                        mcand_next  = {{16{i_DatA[15]}}, i_DatA[15:0]};
                        mplier_next = {{16{b_op[15]}}, b_op[15:0]};
                    end
`endif
                end else if (i_valid) begin
                    valid_next  = 1'b1;
                    result_next = alu_res;
                    store_next  = i_DatB;
                    robj_next   = i_Robj;
                    rw_next     = i_ctrl[5];
                    mr_next     = i_ctrl[6];
                    mw_next     = i_ctrl[7];
                    wb_next     = i_ctrl[16:8];
`ifdef EXE_MAC_EN
                    if (op == OP_CLRACC) acc_next = 32'd0;
`endif
                end else begin
                    valid_next = 1'b0;
                    rw_next    = 1'b0;
                    mr_next    = 1'b0;
                    mw_next    = 1'b0;
                end
            end
            default: begin
                mcand_next  = mcand_reg << 2;
                mplier_next = mplier_reg >> 2;
                prod_next   = prod_step;
                count_next  = count_reg - CW'(1);
                if (count_reg == '0) begin
                    state_next  = S_IDLE;
                    stall_next  = 1'b0;
                    valid_next  = 1'b1;
                    result_next = prod_step;
                    store_next  = pend_store_reg;
                    robj_next   = pend_robj_reg;
                    rw_next     = pend_rw_reg;
                    mr_next     = pend_mr_reg;
                    mw_next     = pend_mw_reg;
                    wb_next     = pend_wb_reg;
`ifdef EXE_MAC_EN
                    if (is_mac_reg) begin
                        acc_next    = mac_sat;
                        result_next = mac_sat;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            count_reg      <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            prod_reg       <= '0;
            pend_robj_reg  <= '0;
            pend_rw_reg    <= 1'b0;
            pend_mr_reg    <= 1'b0;
            pend_mw_reg    <= 1'b0;
            pend_wb_reg    <= '0;
            pend_store_reg <= '0;
            stall_reg      <= 1'b0;
            valid_reg      <= 1'b0;
            result_reg     <= '0;
            store_reg      <= '0;
            robj_reg       <= '0;
            rw_reg         <= 1'b0;
            mr_reg         <= 1'b0;
            mw_reg         <= 1'b0;
            wb_reg         <= '0;
`ifdef EXE_MAC_EN
            acc_reg        <= '0;
            is_mac_reg     <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            mcand_reg      <= mcand_next;
            mplier_reg     <= mplier_next;
            prod_reg       <= prod_next;
            pend_robj_reg  <= pend_robj_next;
            pend_rw_reg    <= pend_rw_next;
            pend_mr_reg    <= pend_mr_next;
            pend_mw_reg    <= pend_mw_next;
            pend_wb_reg    <= pend_wb_next;
            pend_store_reg <= pend_store_next;
            stall_reg      <= stall_next;
            valid_reg      <= valid_next;
            result_reg     <= result_next;
            store_reg      <= store_next;
            robj_reg       <= robj_next;
            rw_reg         <= rw_next;
            mr_reg         <= mr_next;
            mw_reg         <= mw_next;
            wb_reg         <= wb_next;
`ifdef EXE_MAC_EN
            acc_reg        <= acc_next;
            is_mac_reg     <= is_mac_next;
`endif
        end
    end

    assign o_stall      = stall_reg;
    assign o_valid      = valid_reg;
    assign o_result     = result_reg;
    assign o_store_data = store_reg;
    assign o_Robj       = robj_reg;
    assign o_reg_write  = rw_reg;
    assign o_mem_read   = mr_reg;
    assign o_mem_write  = mw_reg;
    assign o_ctrl_wb    = wb_reg;

endmodule
